// File: rtl/instr_fetch_unit_pkg.sv
// instr_fetch_unit_pkg: shared fetch-state encoding, queue entry layout and branch target helper.
package instr_fetch_unit_pkg;

    localparam int INSTR_W = 32;
    localparam int PC_W    = 32;
    localparam int OFF_HI  = 23;
    localparam int OFF_LO  = 16;

    typedef enum logic [1:0] {FETCH, IDLE, DRAIN} fetch_state_t;

    typedef struct packed {
        logic [PC_W-1:0]    pc;
        logic [INSTR_W-1:0] instr;
    } fetch_entry_t;

    function automatic logic [OFF_HI-OFF_LO:0] offset_field(input logic [INSTR_W-1:0] instr);
        return instr[OFF_HI:OFF_LO];
    endfunction

    // Redirect is relative to the instruction after the branch; wraps at 32 bits.
    function automatic logic [PC_W-1:0] branch_target(input logic [PC_W-1:0] pc, input logic [7:0] off);
        return pc + PC_W'(1) + {{(PC_W-8){off[7]}}, off};
    endfunction

endpackage

// File: rtl/instr_queue.sv
// instr_queue: small synchronous FIFO of {PC, instruction} with flush; head is read combinationally.
module instr_queue
    import instr_fetch_unit_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic                     i_clk,
    input  logic                     i_rst_n,
    input  logic                     i_push,
    input  logic                     i_pop,
    input  logic                     i_flush,
    input  fetch_entry_t             i_wdata,
    output fetch_entry_t             o_rdata,
    output logic                     o_empty,
    output logic                     o_full,
    output logic [$clog2(DEPTH):0]   o_count
);

    localparam int AW = $clog2(DEPTH);

    fetch_entry_t   r_mem [DEPTH];
    logic [AW-1:0]  r_wr;
    logic [AW-1:0]  r_rd;
    logic [AW:0]    r_count;

    always_ff @(posedge i_clk) begin
        if (i_push && !i_flush) r_mem[r_wr] <= i_wdata;
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_wr    <= '0;
            r_rd    <= '0;
            r_count <= '0;
        end else if (i_flush) begin
            r_wr    <= '0;
            r_rd    <= '0;
            r_count <= '0;
        end else begin
            if (i_push) r_wr <= r_wr + AW'(1);
            if (i_pop)  r_rd <= r_rd + AW'(1);
            r_count <= r_count + (AW+1)'(i_push) - (AW+1)'(i_pop);
        end
    end

    always @(posedge i_clk) begin
        if (i_rst_n) assert (!(i_push && !i_pop && !i_flush && o_full));
    end

    assign o_rdata = r_mem[r_rd];
    assign o_empty = r_count == '0;
    assign o_full  = r_count == (AW+1)'(DEPTH);
    assign o_count = r_count;

endmodule

// File: rtl/instr_fetch_unit.sv
// instr_fetch_unit: owns the PC, prefetches words over a busy-wait memory handshake
// into a small queue and applies branch redirects from the core.
module instr_fetch_unit
    import instr_fetch_unit_pkg::*;
#(
    parameter logic [31:0] RESET_PC    = 32'd0,
    parameter int          QUEUE_DEPTH = 2,
    parameter int          IMEM_ADDR_W = 10
) (
    input  logic                   CLK,
    input  logic                   RESET,
    output logic [PC_W-1:0]        PC,
    output logic [INSTR_W-1:0]     INSTRUCTION,
    output logic                   INSTR_VALID,
    input  logic                   CPU_STALL,
    input  logic                   BRANCH_TAKEN,
    input  logic [7:0]             BRANCH_OFFSET,
    output logic                   IMEM_READ,
    output logic [IMEM_ADDR_W-1:0] IMEM_ADDRESS,
    input  logic [INSTR_W-1:0]     IMEM_READDATA,
    input  logic                   IMEM_BUSYWAIT
);

    localparam int QW = $clog2(QUEUE_DEPTH);

    fetch_state_t        r_state;
    logic [PC_W-1:0]     r_ptr;
    logic                r_read;
    logic [IMEM_ADDR_W-1:0] r_addr;

    fetch_entry_t        w_head;
    logic                w_empty;
    logic                w_full;
    logic [QW:0]         w_count;
    logic                w_done;
    logic                w_br;
    logic                w_pop;
    logic                w_push;
    logic                w_full_next;
    logic [PC_W-1:0]     w_target;
    logic [PC_W-1:0]     w_ptr_inc;

    assign w_done      = r_read && !IMEM_BUSYWAIT;
    assign w_br        = BRANCH_TAKEN && !w_empty;
    assign w_pop       = !w_empty && !CPU_STALL && !BRANCH_TAKEN;
    assign w_push      = w_done && r_state == FETCH && !w_br;
    assign w_full_next = w_push && (w_pop ? w_full : w_count == (QW+1)'(QUEUE_DEPTH-1));
    assign w_target    = branch_target(w_head.pc, BRANCH_OFFSET);
    assign w_ptr_inc   = r_ptr + PC_W'(1);

    instr_queue #(.DEPTH(QUEUE_DEPTH)) u_queue (
        .i_clk   (CLK),
        .i_rst_n (RESET),
        .i_push  (w_push),
        .i_pop   (w_pop),
        .i_flush (w_br),
        .i_wdata ('{pc: r_ptr, instr: IMEM_READDATA}),
        .o_rdata (w_head),
        .o_empty (w_empty),
        .o_full  (w_full),
        .o_count (w_count)
    );

    // An outstanding request cannot be abandoned, so a redirect during a busy read drains it first.
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            r_state <= FETCH;
            r_ptr   <= RESET_PC;
            r_read  <= 1'b0;
            r_addr  <= '0;
        end else if (w_br) begin
            r_ptr <= w_target;
            if (r_read && IMEM_BUSYWAIT) begin
                r_state <= DRAIN;
            end else begin
                r_state <= FETCH;
                r_read  <= 1'b1;
                r_addr  <= w_target[IMEM_ADDR_W-1:0];
            end
        end else if (r_state == DRAIN) begin
            if (w_done) begin
                r_state <= FETCH;
                r_addr  <= r_ptr[IMEM_ADDR_W-1:0];
            end
        end else if (r_state == IDLE) begin
            if (w_pop) begin
                r_state <= FETCH;
                r_read  <= 1'b1;
                r_addr  <= r_ptr[IMEM_ADDR_W-1:0];
            end
        end else if (w_done) begin
            r_ptr <= w_ptr_inc;
            if (w_full_next) begin
                r_state <= IDLE;
                r_read  <= 1'b0;
            end else begin
                r_addr <= w_ptr_inc[IMEM_ADDR_W-1:0];
            end
        end else begin
            r_read <= 1'b1;
            r_addr <= r_ptr[IMEM_ADDR_W-1:0];
        end
    end

    assign INSTR_VALID  = !w_empty;
    assign PC           = w_empty ? r_ptr : w_head.pc;
    assign INSTRUCTION  = w_empty ? '0 : w_head.instr;
    assign IMEM_READ    = r_read;
    assign IMEM_ADDRESS = r_addr;

endmodule
